// File: rtl/rob_commit_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : rob_commit_ctrl_pkg
// Brief    : Instruction ids, commit classification and ROB FSM encodings.
// Revision : 1.0
// ============================================================================
package rob_commit_ctrl_pkg;

    localparam int C_INSTR_ID_W  = 6;
    localparam int C_ROB_DEPTH   = 16;
    localparam int C_ROB_AW      = 4;
    localparam int C_DATA_W      = 32;

    typedef logic [C_INSTR_ID_W-1:0] instr_id_t;

    // Ids are grouped so that every commit class is a contiguous range.
    localparam instr_id_t C_NOP   = 6'd0;
    localparam instr_id_t C_LB    = 6'd1;
    localparam instr_id_t C_LH    = 6'd2;
    localparam instr_id_t C_LW    = 6'd3;
    localparam instr_id_t C_LBU   = 6'd4;
    localparam instr_id_t C_LHU   = 6'd5;
    localparam instr_id_t C_SB    = 6'd6;
    localparam instr_id_t C_SH    = 6'd7;
    localparam instr_id_t C_SW    = 6'd8;
    localparam instr_id_t C_LUI   = 6'd9;
    localparam instr_id_t C_AUIPC = 6'd10;
    localparam instr_id_t C_JAL   = 6'd11;
    localparam instr_id_t C_JALR  = 6'd12;
    localparam instr_id_t C_BEQ   = 6'd13;
    localparam instr_id_t C_BNE   = 6'd14;
    localparam instr_id_t C_BLT   = 6'd15;
    localparam instr_id_t C_BGE   = 6'd16;
    localparam instr_id_t C_BLTU  = 6'd17;
    localparam instr_id_t C_BGEU  = 6'd18;
    localparam instr_id_t C_ADDI  = 6'd19;
    localparam instr_id_t C_ADD   = 6'd28;
    localparam instr_id_t C_AND   = 6'd37;

    localparam logic [1:0] C_ST_RUN        = 2'd0;
    localparam logic [1:0] C_ST_STORE_WAIT = 2'd1;
    localparam logic [1:0] C_ST_FLUSH      = 2'd2;

    function automatic logic is_regwrite(input instr_id_t id);
        return ((id >= C_LB)   && (id <= C_LHU))  ||
               ((id >= C_LUI)  && (id <= C_JALR)) ||
               ((id >= C_ADDI) && (id <= C_AND));
    endfunction

    function automatic logic is_branch(input instr_id_t id);
        return (id >= C_JAL) && (id <= C_BGEU);
    endfunction

    function automatic logic is_store(input instr_id_t id);
        return (id >= C_SB) && (id <= C_SW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rob_entry_store.sv
`default_nettype none
// ============================================================================
// Module   : rob_entry_store
// Brief    : ROB entry array: issue and CDB write ports, head read, flush clear.
// Revision : 1.0
// ============================================================================
module rob_entry_store
    import rob_commit_ctrl_pkg::*;
#(
    parameter int ROB_DEPTH = C_ROB_DEPTH,
    parameter int ROB_AW    = C_ROB_AW,
    parameter int DATA_W    = C_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_issue_we,
    input  logic [ROB_AW-1:0] i_issue_tag,
    input  instr_id_t         i_issue_id,
    input  logic [4:0]        i_issue_rd,
    input  logic              i_cdb_we,
    input  logic [ROB_AW-1:0] i_cdb_tag,
    input  logic [DATA_W-1:0] i_cdb_value,
    input  logic              i_cdb_jump_en,
    input  logic [DATA_W-1:0] i_cdb_jump_a,
    input  logic              i_retire_we,
    input  logic              i_flush,
    input  logic [ROB_AW-1:0] i_head_tag,
    output logic              o_head_valid,
    output logic              o_head_ready,
    output instr_id_t         o_head_id,
    output logic [4:0]        o_head_rd,
    output logic [DATA_W-1:0] o_head_value,
    output logic              o_head_jump_en,
    output logic [DATA_W-1:0] o_head_jump_a
);

    logic              r_valid   [ROB_DEPTH];
    logic              r_ready   [ROB_DEPTH];
    instr_id_t         r_id      [ROB_DEPTH];
    logic [4:0]        r_rd      [ROB_DEPTH];
    logic [DATA_W-1:0] r_value   [ROB_DEPTH];
    logic              r_jump_en [ROB_DEPTH];
    logic [DATA_W-1:0] r_jump_a  [ROB_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_valid[i]   <= 1'b0;
                r_ready[i]   <= 1'b0;
                r_id[i]      <= '0;
                r_rd[i]      <= '0;
                r_value[i]   <= '0;
                r_jump_en[i] <= 1'b0;
                r_jump_a[i]  <= '0;
            end
        end else if (i_flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_ready[i] <= 1'b0;
            end
        end else begin
            // Completions to unallocated slots are stale broadcasts.
            if (i_cdb_we && r_valid[i_cdb_tag]) begin
                r_value[i_cdb_tag]   <= i_cdb_value;
                r_jump_en[i_cdb_tag] <= i_cdb_jump_en;
                r_jump_a[i_cdb_tag]  <= i_cdb_jump_a;
                r_ready[i_cdb_tag]   <= 1'b1;
            end
            if (i_retire_we) begin
                r_valid[i_head_tag] <= 1'b0;
                r_ready[i_head_tag] <= 1'b0;
            end
            if (i_issue_we) begin
                r_valid[i_issue_tag]   <= 1'b1;
                r_ready[i_issue_tag]   <= 1'b0;
                r_id[i_issue_tag]      <= i_issue_id;
                r_rd[i_issue_tag]      <= i_issue_rd;
                r_jump_en[i_issue_tag] <= 1'b0;
            end
        end
    end

    assign o_head_valid   = r_valid[i_head_tag];
    assign o_head_ready   = r_ready[i_head_tag];
    assign o_head_id      = r_id[i_head_tag];
    assign o_head_rd      = r_rd[i_head_tag];
    assign o_head_value   = r_value[i_head_tag];
    assign o_head_jump_en = r_jump_en[i_head_tag];
    assign o_head_jump_a  = r_jump_a[i_head_tag];

endmodule
`default_nettype wire

// File: rtl/rob_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rob_commit_ctrl
// Brief    : In-order ROB allocation, completion tracking and commit sequencing.
// Revision : 1.0
// ============================================================================
module rob_commit_ctrl
    import rob_commit_ctrl_pkg::*;
#(
    parameter int ROB_DEPTH = C_ROB_DEPTH,
    parameter int ROB_AW    = C_ROB_AW,
    parameter int DATA_W    = C_DATA_W
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              issue_en_in,
    input  instr_id_t         issue_instr_id_in,
    input  logic [4:0]        issue_rd_in,
    output logic [ROB_AW-1:0] issue_tag_out,
    output logic              rob_full_out,
    input  logic              cdb_en_in,
    input  logic [ROB_AW-1:0] cdb_tag_in,
    input  logic [DATA_W-1:0] cdb_value_in,
    input  logic              cdb_jump_en_in,
    input  logic [DATA_W-1:0] cdb_jump_a_in,
    input  logic              lsb_store_done_in,
    output logic [ROB_AW-1:0] commit_tag_out,
    output logic [4:0]        commit_rd_out,
    output logic [DATA_W-1:0] commit_value_out,
    output logic              commit_to_regfile_en_out,
    output logic              commit_to_lsb_en_out,
    output logic              commit_to_pc_en_out,
    output logic [DATA_W-1:0] commit_to_pc_out,
    output logic              clear_branch_out
);

    logic [1:0]        r_state, w_state_next;
    logic [ROB_AW-1:0] r_head, r_tail;
    logic [ROB_AW:0]   r_count;

    logic              w_head_valid, w_head_ready, w_head_jump_en;
    instr_id_t         w_head_id;
    logic [4:0]        w_head_rd;
    logic [DATA_W-1:0] w_head_value, w_head_jump_a;

    logic w_issue, w_cdb_we, w_flush, w_head_live, w_head_store, w_head_redirect;
    logic w_commit_rf, w_commit_lsb, w_commit_pc, w_advance;

    assign rob_full_out  = (r_count == (ROB_AW+1)'(ROB_DEPTH)) || (r_state != C_ST_RUN);
    assign issue_tag_out = r_tail;

    assign w_issue   = rdy_in && issue_en_in && !rob_full_out;
    assign w_cdb_we  = rdy_in && cdb_en_in && (r_state != C_ST_FLUSH);
    assign w_flush   = rdy_in && (r_state == C_ST_FLUSH);

    // Empty is judged by count, so stale slot contents never look committable.
    assign w_head_live     = (r_count != '0) && w_head_valid && w_head_ready;
    assign w_head_store    = is_store(w_head_id);
    assign w_head_redirect = is_branch(w_head_id) && w_head_jump_en;

    rob_entry_store #(
        .ROB_DEPTH (ROB_DEPTH),
        .ROB_AW    (ROB_AW),
        .DATA_W    (DATA_W)
    ) u_entries (
        .clk            (clk_in),
        .rst_n          (rst_n_in),
        .i_issue_we     (w_issue),
        .i_issue_tag    (r_tail),
        .i_issue_id     (issue_instr_id_in),
        .i_issue_rd     (issue_rd_in),
        .i_cdb_we       (w_cdb_we),
        .i_cdb_tag      (cdb_tag_in),
        .i_cdb_value    (cdb_value_in),
        .i_cdb_jump_en  (cdb_jump_en_in),
        .i_cdb_jump_a   (cdb_jump_a_in),
        .i_retire_we    (rdy_in && w_advance),
        .i_flush        (w_flush),
        .i_head_tag     (r_head),
        .o_head_valid   (w_head_valid),
        .o_head_ready   (w_head_ready),
        .o_head_id      (w_head_id),
        .o_head_rd      (w_head_rd),
        .o_head_value   (w_head_value),
        .o_head_jump_en (w_head_jump_en),
        .o_head_jump_a  (w_head_jump_a)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= C_ST_RUN;
        end else if (rdy_in) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_ST_RUN: begin
                if (w_head_live && w_head_store) begin
                    w_state_next = C_ST_STORE_WAIT;
                end else if (w_head_live && w_head_redirect) begin
                    w_state_next = C_ST_FLUSH;
                end
            end
            C_ST_STORE_WAIT: begin
                if (lsb_store_done_in) begin
                    w_state_next = C_ST_RUN;
                end
            end
            default: w_state_next = C_ST_RUN;
        endcase
    end

    always_comb begin
        w_commit_rf  = 1'b0;
        w_commit_lsb = 1'b0;
        w_commit_pc  = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            C_ST_RUN: begin
                if (w_head_live) begin
                    if (w_head_store) begin
                        w_commit_lsb = 1'b1;
                    end else begin
                        w_commit_rf = is_regwrite(w_head_id);
                        w_commit_pc = w_head_redirect;
                        w_advance   = !w_head_redirect;
                    end
                end
            end
            C_ST_STORE_WAIT: w_advance = lsb_store_done_in;
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_head                   <= '0;
            r_tail                   <= '0;
            r_count                  <= '0;
            commit_tag_out           <= '0;
            commit_rd_out            <= '0;
            commit_value_out         <= '0;
            commit_to_regfile_en_out <= 1'b0;
            commit_to_lsb_en_out     <= 1'b0;
            commit_to_pc_en_out      <= 1'b0;
            commit_to_pc_out         <= '0;
            clear_branch_out         <= 1'b0;
        end else if (!rdy_in) begin
            commit_to_regfile_en_out <= 1'b0;
            commit_to_lsb_en_out     <= 1'b0;
            commit_to_pc_en_out      <= 1'b0;
            clear_branch_out         <= 1'b0;
        end else begin
            commit_to_regfile_en_out <= w_commit_rf;
            commit_to_lsb_en_out     <= w_commit_lsb;
            commit_to_pc_en_out      <= w_commit_pc;
            clear_branch_out         <= w_commit_pc;
            if (w_commit_rf || w_commit_lsb || w_commit_pc) begin
                commit_tag_out   <= r_head;
                commit_rd_out    <= w_head_rd;
                commit_value_out <= w_head_value;
            end
            if (w_commit_pc) begin
                commit_to_pc_out <= w_head_jump_a;
            end
            if (w_flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_issue) begin
                    r_tail <= r_tail + ROB_AW'(1);
                end
                if (w_advance) begin
                    r_head <= r_head + ROB_AW'(1);
                end
                if (w_issue && !w_advance) begin
                    r_count <= r_count + (ROB_AW+1)'(1);
                end else if (!w_issue && w_advance) begin
                    r_count <= r_count - (ROB_AW+1)'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire
